// File: rtl/jfpjc_pkg.sv
// jfpjc_pkg: shared FSM encoding and constants for the JPEG strip pipeline
package jfpjc_pkg;
  localparam int BLOCK_DIM = 8;
  localparam int EBR_ADDR_W = 9;
  localparam int DEF_NUM_BLOCKS = 5;
  localparam int DEF_STRIPS_PER_FRAME = 30;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BLOCK, FINISH} sched_state_t;
endpackage

// File: rtl/jpeg_strip_scheduler_strip_counter.sv
// strip_counter: modulo-MOD counter with synchronous clear and increment
module strip_counter #(
  parameter int MOD = 30,
  parameter int W = 5
) (
  input  logic         clock,
  input  logic         nreset,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);
  logic [W-1:0] r_count;
  // clear wins, but an increment in the same cycle consumes the cleared value 0
  always_ff @(posedge clock or negedge nreset)
    if (!nreset) r_count <= '0;
    else if (i_clr) r_count <= (i_inc && MOD > 1) ? W'(1) : '0;
    else if (i_inc) r_count <= (r_count == W'(MOD - 1)) ? '0 : r_count + 1'b1;
  assign o_count = r_count;
endmodule

// File: rtl/jpeg_strip_scheduler.sv
// jpeg_strip_scheduler: ping-pong strip ownership and per-block compressor sequencing; JFPJC_SCHED_STATS_EN adds drop/frame counters
module jpeg_strip_scheduler
  import jfpjc_pkg::*;
#(
  parameter int NUM_BLOCKS = DEF_NUM_BLOCKS,
  parameter int STRIPS_PER_FRAME = DEF_STRIPS_PER_FRAME,
  parameter int IDX_W = 5
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             ing_frame_start,
  input  logic             ing_strip_done,
  output logic             frontbuffer_select,
  output logic             cmp_block_start,
  output logic [2:0]       cmp_block_sel,
  input  logic             cmp_block_done,
  output logic [IDX_W-1:0] strip_index,
  output logic             frame_done,
  output logic             busy,
  output logic             overrun
`ifdef JFPJC_SCHED_STATS_EN
  ,
  output logic [7:0]       dropped_strips,
  output logic [7:0]       frame_count
`endif
);
  sched_state_t     r_state;
  logic             r_fb, r_start, r_fd, r_busy, r_ovr;
  logic [2:0]       r_sel;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_count;
  logic [IDX_W-1:0] w_next_idx;
  logic             w_drop;
  strip_counter #(.MOD(STRIPS_PER_FRAME), .W(IDX_W)) u_wr_cnt (
    .clock  (clock),
    .nreset (nreset),
    .i_clr  (ing_frame_start),
    .i_inc  (ing_strip_done),
    .o_count(w_count)
  );
  assign w_next_idx = ing_frame_start ? '0 : w_count;
  assign w_drop = ing_strip_done && r_state != IDLE;
  // strip handoff, block issue/wait sequencing and sticky overrun
  always_ff @(posedge clock or negedge nreset)
    if (!nreset) begin
      r_state <= IDLE;
      r_fb    <= 1'b0;
      r_start <= 1'b0;
      r_sel   <= '0;
      r_idx   <= '0;
      r_fd    <= 1'b0;
      r_busy  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_fd    <= 1'b0;
      if (w_drop) r_ovr <= 1'b1;
      case (r_state)
        IDLE: if (ing_strip_done) begin
          r_fb    <= ~r_fb;
          r_idx   <= w_next_idx;
          r_sel   <= '0;
          r_busy  <= 1'b1;
          r_state <= ISSUE;
        end
        ISSUE: begin
          r_start <= 1'b1;
          r_state <= WAIT_BLOCK;
        end
        WAIT_BLOCK: if (cmp_block_done) begin
          if (r_sel < 3'(NUM_BLOCKS - 1)) begin
            r_sel   <= r_sel + 1'b1;
            r_state <= ISSUE;
          end else begin
            r_busy  <= 1'b0;
            r_fd    <= r_idx == IDX_W'(STRIPS_PER_FRAME - 1);
            r_state <= FINISH;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  assign frontbuffer_select = r_fb;
  assign cmp_block_start    = r_start;
  assign cmp_block_sel      = r_sel;
  assign strip_index        = r_idx;
  assign frame_done         = r_fd;
  assign busy               = r_busy;
  assign overrun            = r_ovr;
`ifdef JFPJC_SCHED_STATS_EN
  logic [7:0] r_drops, r_frames;
  // saturating overrun count and wrapping count of completed frames
  always_ff @(posedge clock or negedge nreset)
    if (!nreset) begin
      r_drops  <= '0;
      r_frames <= '0;
    end else begin
      if (w_drop && r_drops != 8'hFF) r_drops <= r_drops + 1'b1;
      if (r_fd) r_frames <= r_frames + 1'b1;
    end
  assign dropped_strips = r_drops;
  assign frame_count    = r_frames;
`endif
endmodule

// File: doc/jpeg_strip_scheduler.md
Name: jpeg_strip_scheduler

Overview:
Sequences the ping-pong EBR strip buffers between the hm01b0 ingester (writer) and the JPEG block pipeline (reader). Tracks which half each side owns and swaps halves when the ingester finishes an 8-line strip. Then issues the NUM_BLOCKS 8x8 blocks of that strip to the compressor one at a time, waiting for a done handshake on each. Detects and reports strip overruns.

Parameters:
NUM_BLOCKS, 5, 8x8 blocks per strip (one EBR each); legal range 1..8
STRIPS_PER_FRAME, 30, strips per frame; strip index wraps after this
IDX_W, 5, width of strip index; must satisfy 2^IDX_W >= STRIPS_PER_FRAME

Ports:
clock  in  1  system clock
nreset  in  1  asynchronous active-low reset
ing_frame_start  in  1  one-cycle pulse: ingester saw start of frame
ing_strip_done  in  1  one-cycle pulse: ingester finished a strip in the write half
frontbuffer_select  out  1  half the ingester writes; reader uses the complement
cmp_block_start  out  1  one-cycle pulse: compressor may begin block cmp_block_sel
cmp_block_sel  out  3  EBR/block index the compressor reads
cmp_block_done  in  1  one-cycle pulse: compressor finished current block
strip_index  out  IDX_W  index of the strip being compressed
frame_done  out  1  one-cycle pulse after last block of strip STRIPS_PER_FRAME-1
busy  out  1  high while a strip is being compressed
overrun  out  1  sticky: ingester completed a strip while reader still busy

Behaviour:
- Reset (async, nreset low): state IDLE. frontbuffer_select=0, cmp_block_start=0, cmp_block_sel=0, strip_index=0, frame_done=0, busy=0, overrun=0. Internal write-strip counter=0. Reset mid-strip abandons the strip; no done pulses are emitted.
- FSM states: IDLE, ISSUE, WAIT_BLOCK, FINISH.
- IDLE, ing_strip_done=1: toggle frontbuffer_select. Latch strip_index := write-strip counter. Increment the counter, wrapping STRIPS_PER_FRAME-1 -> 0. Set cmp_block_sel=0 and busy=1. Go to ISSUE.
- ISSUE: assert cmp_block_start for exactly one cycle. Go to WAIT_BLOCK.
- WAIT_BLOCK, on cmp_block_done:
  - if cmp_block_sel < NUM_BLOCKS-1: increment cmp_block_sel and go to ISSUE. Start follows done by exactly 2 cycles.
  - else go to FINISH.
- cmp_block_done outside WAIT_BLOCK is ignored.
- FINISH (1 cycle): busy=0. frame_done=1 for this cycle if strip_index == STRIPS_PER_FRAME-1. Go to IDLE.
- Latency: ing_strip_done in IDLE at cycle N -> frontbuffer_select toggles and busy rises at N+1; first cmp_block_start is high during N+2.
- Overrun: ing_strip_done in any state other than IDLE sets overrun, which stays set until reset.
  - No swap occurs; the ingester overwrites the same half.
  - The write-strip counter still increments, so the strip numbering stays frame-accurate.
- ing_frame_start: write-strip counter := 0 in any state. The strip in flight completes with its latched strip_index.
  - ing_frame_start and ing_strip_done in the same cycle: the strip is accepted/dropped as index 0, and the counter becomes 1.
- frontbuffer_select changes only on an accepted strip_done.

Optional Feature:
JFPJC_SCHED_STATS_EN.
- Defined: adds output dropped_strips [7:0], a count of overrun events that saturates at 255 and is cleared by reset. Also adds output frame_count [7:0], which increments (wrapping) on each frame_done.
- Undefined: neither port nor its counters exists; all other behaviour is identical.

Decomposition:
- Shared package jfpjc_pkg holds:
  - FSM state encoding (sched_state_t: IDLE, ISSUE, WAIT_BLOCK, FINISH)
  - constants BLOCK_DIM=8 and EBR_ADDR_W=9
  - defaults for NUM_BLOCKS and STRIPS_PER_FRAME
- One natural sub-module: strip_counter, a wrapping modulo-STRIPS_PER_FRAME counter with synchronous clear (frame_start) and increment (strip_done). It is reused by the ingester for line counting.
- Everything else stays flat.

Test Plan:
1. Reset release, then ing_strip_done at cycle 10 -> frontbuffer_select=1 at cycle 11. cmp_block_start pulses at 12. Respond with done 3 cycles after each start: 5 starts with cmp_block_sel 0..4; busy falls one cycle after the 5th done.
2. 30 strips with the compressor fast enough, after ing_frame_start -> strip_index 0..29. Exactly one frame_done, on the FINISH of strip 29. frontbuffer_select toggles 30 times, ending at 0. overrun=0.
3. ing_strip_done while in WAIT_BLOCK of block 2 -> overrun=1 next cycle and stays set. frontbuffer_select unchanged. The current strip still issues blocks 3 and 4. The next accepted strip reports strip_index+2.
4. ing_frame_start mid-strip (strip_index=7) -> strip 7 completes normally. The next accepted strip has strip_index=0, and no frame_done is generated.
5. nreset asserted during WAIT_BLOCK of block 3 -> all outputs go to reset values immediately (asynchronous). A later cmp_block_done is ignored. The next strip starts at block 0 and frontbuffer_select=1.
6. With JFPJC_SCHED_STATS_EN defined, force 300 overruns -> dropped_strips saturates at 255. Two full frames -> frame_count=2.
